cache_way_ctrl: RTL and testbench

- Sequencing controller for the N-way set-associative cache.
- Accepts CPU read/write requests and qualifies the external tag-comparator hit vector with its internal valid bits.
- Drives the write strobes and one-hot way decode into the tag/data flop arrays, which capture on the falling clock edge.
- Runs line refills from memory and keeps true-LRU ages and valid bits per set. Policy: write-through, no-write-allocate.

---
 rtl/cache_way_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_cache_way_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_ctrl.sv
// -----------------------------------------------------------------------------
// cache_way_ctrl
//
// Sequencing controller for an N-way set-associative, write-through,
// no-write-allocate cache. It qualifies the external tag-comparator hit vector
// with its own valid bits, drives the write strobes and one-hot way decode
// into the tag/data flop arrays (which capture on the falling clock edge),
// runs line refills from memory and keeps true-LRU ages per set.
//
// Parameters
//   WAYS   associativity (power of 2, >= 2)
//   SETS   number of sets (power of 2, >= 2)
//   WORDS  words per line (power of 2, >= 2)
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-high reset
//   cpu_req/we/set      CPU request, held until cpu_ack
//   cpu_ack             one-cycle completion pulse
//   hit_vec             raw tag match per way for set_idx
//   set_idx             set index presented to the arrays
//   way_sel, word_idx   one-hot way and word select for array writes
//   tag_we, data_we     array write strobes
//   data_src            0 = CPU write data, 1 = memory read data
//   mem_req/we/ack      memory request handshake (we: 1 = write-through)
//   mem_rvalid          one refill beat valid
//   busy                controller not idle
//
// Optional feature
//   CACHE_STATS_EN      adds 32-bit saturating stat_hits / stat_misses
//                       outputs counting LOOKUP outcomes.
// -----------------------------------------------------------------------------
module cache_way_ctrl #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [$clog2(SETS)-1:0]  cpu_set,
  output logic                     cpu_ack,
  input  logic [WAYS-1:0]          hit_vec,
  output logic [$clog2(SETS)-1:0]  set_idx,
  output logic [WAYS-1:0]          way_sel,
  output logic [$clog2(WORDS)-1:0] word_idx,
  output logic                     tag_we,
  output logic                     data_we,
  output logic                     data_src,
  output logic                     mem_req,
  output logic                     mem_we,
  input  logic                     mem_ack,
  input  logic                     mem_rvalid,
  output logic                     busy
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORD_W = $clog2(WORDS);
  localparam logic [WAY_W-1:0]  AGE_OLDEST = WAY_W'(WAYS - 1);
  localparam logic [WORD_W-1:0] LAST_BEAT  = WORD_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RF_REQ,
    S_RF_DATA,
    S_WT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic              we_q, we_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];
  logic [WAY_W-1:0]  age_d   [SETS][WAYS];

  logic [WAYS-1:0]   hit_mask;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim_way;
  logic              lru_en;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  strobe_way;

  // Lookup helpers for the currently latched set. Loops run from the top way
  // down so the lowest matching index is the one that sticks.
  always_comb begin
    hit_mask   = hit_vec & valid_q[set_q];
    hit_any    = |hit_mask;
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_mask[w]) hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[set_q][w] == AGE_OLDEST) victim_way = WAY_W'(w);
    end
    // Any invalid way beats the LRU way as refill victim.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_q][w]) victim_way = WAY_W'(w);
    end
  end

  // Next-state and output logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    we_d       = we_q;
    victim_d   = victim_q;
    beat_d     = beat_q;
    valid_d    = valid_q;
    age_d      = age_q;
    lru_en     = 1'b0;
    lru_way    = '0;
    strobe_way = '0;
    cpu_ack    = 1'b0;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_src   = 1'b0;
    word_idx   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          set_d   = cpu_set;
          we_d    = cpu_we;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit_any) begin
          lru_en  = 1'b1;
          lru_way = hit_way;
          if (we_q) begin
            data_we    = 1'b1;
            strobe_way = hit_way;
            state_d    = S_WT;
          end else begin
            state_d = S_RESP;
          end
        end else if (we_q) begin
          // No-write-allocate: a write miss only goes to memory.
          state_d = S_WT;
        end else begin
          victim_d = victim_way;
          state_d  = S_RF_REQ;
        end
      end

      S_RF_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          beat_d  = '0;
          state_d = S_RF_DATA;
        end
      end

      S_RF_DATA: begin
        if (mem_rvalid) begin
          data_we    = 1'b1;
          data_src   = 1'b1;
          strobe_way = victim_q;
          word_idx   = beat_q;
          beat_d     = beat_q + WORD_W'(1);
          // The line becomes valid only with its final beat, so an aborted
          // refill never leaves a half-written line looking valid.
          if (beat_q == LAST_BEAT) begin
            tag_we                   = 1'b1;
            valid_d[set_q][victim_q] = 1'b1;
            lru_en                   = 1'b1;
            lru_way                  = victim_q;
            state_d                  = S_RESP;
          end
        end
      end

      S_WT: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = S_RESP;
      end

      S_RESP: begin
        cpu_ack = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // True LRU: ways younger than the accessed one age by one, the accessed
    // way becomes 0. This keeps each set's ages a permutation.
    if (lru_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[set_q][w] < age_q[set_q][lru_way]) begin
          age_d[set_q][w] = age_q[set_q][w] + WAY_W'(1);
        end
      end
      age_d[set_q][lru_way] = '0;
    end

    way_sel = data_we ? (WAYS'(1) << strobe_way) : '0;
  end

  assign set_idx = set_q;
  assign busy    = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      set_q    <= '0;
      we_q     <= 1'b0;
      victim_q <= '0;
      beat_q   <= '0;
      // NOTE: the valid and age tables are explicitly reset because their
      // power-up contents define cache behaviour (invalid lines, ordered ages).
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      we_q     <= we_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      age_q    <= age_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  // One count per LOOKUP outcome, saturating at all-ones.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == S_LOOKUP) begin
      if (hit_any && (hits_q != '1))    hits_d   = hits_q + 32'd1;
      if (!hit_any && (misses_q != '1)) misses_d = misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_way_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_way_ctrl
//
// Self-checking bench for cache_way_ctrl. A behavioural model keeps per-set
// valid bits and a recency list (most recent first); a way's age is its
// position in that list. Each transaction is predicted from the model
// (read hit / write hit / read miss / write miss) and the DUT's strobes,
// memory handshake and acknowledge timing are compared against it. A small
// memory responder inside the transaction task acks after a chosen delay and
// delivers refill beats with random gaps.
// Cycle numbering: edge 0 samples cpu_req; "cycle n" ends at edge n.
// -----------------------------------------------------------------------------
module tb_cache_way_ctrl;
  localparam int WAYS   = 4;
  localparam int SETS   = 8;
  localparam int WORDS  = 4;
  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORD_W = $clog2(WORDS);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [SET_W-1:0]  cpu_set = '0;
  logic              cpu_ack;
  logic [WAYS-1:0]   hit_vec = '0;
  logic [SET_W-1:0]  set_idx;
  logic [WAYS-1:0]   way_sel;
  logic [WORD_W-1:0] word_idx;
  logic              tag_we, data_we, data_src;
  logic              mem_req, mem_we;
  logic              mem_ack = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic              busy;
`ifdef CACHE_STATS_EN
  logic [31:0]       stat_hits, stat_misses;
`endif

  cache_way_ctrl #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_set(cpu_set), .cpu_ack(cpu_ack),
    .hit_vec(hit_vec), .set_idx(set_idx), .way_sel(way_sel), .word_idx(word_idx),
    .tag_we(tag_we), .data_we(data_we), .data_src(data_src),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .busy(busy)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  bit valid_m [SETS][WAYS];
  int lru_m   [SETS][$];   // most recently used first
  int hits_m, misses_m;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      lru_m[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        valid_m[s][w] = 1'b0;
        lru_m[s].push_back(w);
      end
    end
    hits_m   = 0;
    misses_m = 0;
  endfunction

  function automatic void model_touch(int s, int w);
    for (int i = 0; i < lru_m[s].size(); i++) begin
      if (lru_m[s][i] == w) begin
        lru_m[s].delete(i);
        break;
      end
    end
    lru_m[s].push_front(w);
  endfunction

  function automatic int model_age(int s, int w);
    for (int i = 0; i < lru_m[s].size(); i++) if (lru_m[s][i] == w) return i;
    return -1;
  endfunction

  function automatic int model_victim(int s);
    for (int w = 0; w < WAYS; w++) if (!valid_m[s][w]) return w;
    return lru_m[s][lru_m[s].size() - 1];
  endfunction

  function automatic int way_of(logic [WAYS-1:0] oh);
    for (int w = 0; w < WAYS; w++) if (oh[w]) return w;
    return -1;
  endfunction

  // ---------------- helpers ----------------
  task automatic do_reset();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_set = '0; hit_vec = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic check_ages_model(int s);
    for (int w = 0; w < WAYS; w++) begin
      n_checks++;
      if (dut.age_q[s][w] !== WAY_W'(model_age(s, w))) begin
        n_fail++;
        $display("FAIL age set %0d way %0d: got %0d expected %0d", s, w,
                 dut.age_q[s][w], model_age(s, w));
      end
    end
  endtask

  // One CPU transaction with a built-in memory responder.
  //   ack_dly     cycles of mem_req before mem_ack (0 = same cycle)
  //   rv_pct      probability (%) of a refill beat per cycle
  //   hold        keep cpu_req high after the ack (next txn follows at once)
  //   abort_beats >0: assert reset after that many refill beats
  task automatic txn(input bit we, input int s, input logic [WAYS-1:0] hv,
                     input int ack_dly, input int rv_pct, input bit hold,
                     input int abort_beats, output int rf_way, output int ack_at);
    int  h, kind, exp_way, cyc, memack_cyc, last_beat_cyc, tag_cyc;
    int  n_we, n_tag, beats, wait_cnt, exp_ack, exp_we_n;
    bit  mem_seen, memwe_bad, rf_active, in_data, beat, done;
    logic [WAYS+WORD_W+1:0] act_v, exp_v;

    h = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (hv[w] && valid_m[s][w]) h = w;
    if (h >= 0) kind = we ? 1 : 0;    // 0 read hit, 1 write hit
    else        kind = we ? 3 : 2;    // 2 read miss, 3 write miss
    exp_way = (kind == 2) ? model_victim(s) : h;

    rf_way = -1; ack_at = -1; memack_cyc = -1; last_beat_cyc = -1; tag_cyc = -1;
    n_we = 0; n_tag = 0; beats = 0; wait_cnt = 0;
    mem_seen = 0; memwe_bad = 0; rf_active = 0; done = 0;

    cpu_req = 1'b1; cpu_we = we; cpu_set = SET_W'(s); hit_vec = hv;
    mem_ack = 1'b0; mem_rvalid = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    cyc = 1;

    while (!done) begin
      if (abort_beats > 0 && beats == abort_beats) begin
        reset = 1'b1; mem_rvalid = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; cpu_req = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({busy, cpu_ack, mem_req, data_we, tag_we} !== 5'b0) begin
          n_fail++;
          $display("FAIL abort_idle: got busy/ack/mreq/dwe/twe=%b expected 00000",
                   {busy, cpu_ack, mem_req, data_we, tag_we});
        end
        n_checks++;
        if (ack_at != -1) begin
          n_fail++;
          $display("FAIL abort_no_ack: got ack at cycle %0d expected none", ack_at);
        end
        return;
      end

      // Memory side for this cycle.
      in_data    = rf_active;
      mem_rvalid = in_data ? 1'($urandom_range(0, 99) < rv_pct) : 1'($urandom_range(0, 1));
      beat       = in_data && mem_rvalid;
      mem_ack    = 1'b0;
      if (mem_req) begin
        mem_seen = 1;
        if (mem_we !== we) memwe_bad = 1;
        if (wait_cnt == ack_dly) begin
          mem_ack    = 1'b1;
          memack_cyc = cyc;
          if (!we) rf_active = 1;
        end else begin
          wait_cnt++;
        end
      end
      #1;

      if (data_we === 1'b1) begin
        n_we++;
        rf_way = way_of(way_sel);
        if (kind == 1 || kind == 2) begin
          exp_v = {(WAYS'(1) << exp_way), 1'(kind == 2), WORD_W'(kind == 2 ? n_we - 1 : 0), 1'b1};
          act_v = {way_sel, data_src, word_idx, (kind == 2) ? beat : 1'(cyc == 1)};
          n_checks++;
          if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL strobe set %0d cyc %0d: got way/src/word/ontime=%b expected %b",
                     s, cyc, act_v, exp_v);
          end
        end
      end
      if (tag_we === 1'b1) begin
        n_tag++;
        tag_cyc = cyc;
      end
      if (beat) begin
        beats++;
        if (beats == WORDS) begin
          last_beat_cyc = cyc;
          rf_active     = 0;
        end
      end
      if (cpu_ack === 1'b1) begin
        ack_at  = cyc;
        done    = 1;
        cpu_req = hold;
      end else if (cyc >= 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout set %0d: got no cpu_ack by cycle %0d expected ack", s, cyc);
        do_reset();
        return;
      end
      @(posedge clk); #1;
      if (!done) cyc++;
    end

    // Cycle after the ack: back in IDLE, pulse gone, not re-accepted yet.
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    #1;
    n_checks++;
    if ({busy, cpu_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_ack set %0d: got busy/ack=%b expected 00", s, {busy, cpu_ack});
    end

    exp_we_n = (kind == 1) ? 1 : (kind == 2) ? WORDS : 0;
    n_checks++;
    if (n_we != exp_we_n) begin
      n_fail++;
      $display("FAIL data_we_count set %0d kind %0d: got %0d expected %0d", s, kind, n_we, exp_we_n);
    end

    exp_ack = (kind == 0) ? 2 : (kind == 2) ? last_beat_cyc + 1 : memack_cyc + 1;
    n_checks++;
    if (ack_at != exp_ack) begin
      n_fail++;
      $display("FAIL ack_latency set %0d kind %0d: got %0d expected %0d", s, kind, ack_at, exp_ack);
    end

    n_checks++;
    if (mem_seen != (kind != 0) || memwe_bad) begin
      n_fail++;
      $display("FAIL mem_req set %0d kind %0d: got seen=%0d we_bad=%0d expected seen=%0d we_bad=0",
               s, kind, mem_seen, memwe_bad, kind != 0);
    end

    n_checks++;
    if (n_tag != ((kind == 2) ? 1 : 0) || (kind == 2 && tag_cyc != last_beat_cyc)) begin
      n_fail++;
      $display("FAIL tag_we set %0d kind %0d: got count=%0d cyc=%0d expected count=%0d cyc=%0d",
               s, kind, n_tag, tag_cyc, kind == 2, last_beat_cyc);
    end

    case (kind)
      0, 1: begin model_touch(s, h); hits_m++; end
      2: begin valid_m[s][exp_way] = 1'b1; model_touch(s, exp_way); misses_m++; end
      default: misses_m++;
    endcase

`ifdef CACHE_STATS_EN
    n_checks++;
    if (stat_hits !== 32'(hits_m) || stat_misses !== 32'(misses_m)) begin
      n_fail++;
      $display("FAIL stats: got hits=%0d misses=%0d expected hits=%0d misses=%0d",
               stat_hits, stat_misses, hits_m, misses_m);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({busy, cpu_ack, mem_req, mem_we, tag_we, data_we, data_src, way_sel, set_idx, word_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {busy, cpu_ack, mem_req, mem_we, tag_we, data_we, data_src, way_sel, set_idx, word_idx});
    end
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        n_checks++;
        if (dut.age_q[s][w] !== WAY_W'(w)) begin
          n_fail++;
          $display("FAIL reset_age set %0d way %0d: got %0d expected %0d", s, w, dut.age_q[s][w], w);
        end
      end
    end
  endtask

  task automatic test_refill_and_hit();
    int rf, ack;
    do_reset();
    txn(1'b0, 3, 4'b0001, 1, 60, 1'b0, 0, rf, ack);
    n_checks++;
    if (rf != 0) begin
      n_fail++;
      $display("FAIL first_miss_victim: got way %0d expected 0", rf);
    end
    txn(1'b0, 3, 4'b0001, 0, 60, 1'b0, 0, rf, ack);
    n_checks++;
    if (ack != 2 || rf != -1) begin
      n_fail++;
      $display("FAIL read_hit: got ack cycle %0d refill way %0d expected 2 and none", ack, rf);
    end
    for (int w = 0; w < WAYS; w++) begin
      n_checks++;
      if (dut.age_q[3][w] !== WAY_W'(w)) begin
        n_fail++;
        $display("FAIL hit_age way %0d: got %0d expected %0d", w, dut.age_q[3][w], w);
      end
    end
  endtask

  task automatic test_lru_victims();
    int rf, ack;
    do_reset();
    for (int i = 0; i < WAYS; i++) begin
      txn(1'b0, 5, 4'b0000, i % 3, 70, 1'b0, 0, rf, ack);
      n_checks++;
      if (rf != i) begin
        n_fail++;
        $display("FAIL fill_victim %0d: got way %0d expected %0d", i, rf, i);
      end
    end
    txn(1'b0, 5, 4'b0000, 1, 70, 1'b0, 0, rf, ack);
    n_checks++;
    if (rf != 0) begin
      n_fail++;
      $display("FAIL lru_victim_full: got way %0d expected 0", rf);
    end
    txn(1'b0, 5, 4'b0010, 0, 70, 1'b0, 0, rf, ack);
    txn(1'b0, 5, 4'b0000, 2, 70, 1'b0, 0, rf, ack);
    n_checks++;
    if (rf != 2) begin
      n_fail++;
      $display("FAIL lru_victim_after_hit: got way %0d expected 2", rf);
    end
    check_ages_model(5);
  endtask

  task automatic test_write();
    int rf, ack;
    do_reset();
    for (int i = 0; i < 3; i++) txn(1'b0, 1, 4'b0000, 0, 80, 1'b0, 0, rf, ack);
    txn(1'b1, 1, 4'b0100, 1, 80, 1'b0, 0, rf, ack);
    n_checks++;
    if (rf != 2) begin
      n_fail++;
      $display("FAIL write_hit_way: got way %0d expected 2", rf);
    end
    txn(1'b1, 1, 4'b1000, 0, 80, 1'b0, 0, rf, ack);
    n_checks++;
    if (rf != -1) begin
      n_fail++;
      $display("FAIL write_miss_no_alloc: got strobe on way %0d expected none", rf);
    end
  endtask

  task automatic test_reset_abort();
    int rf, ack;
    do_reset();
    txn(1'b0, 6, 4'b0000, 0, 100, 1'b0, 2, rf, ack);
    txn(1'b0, 6, 4'b1111, 0, 100, 1'b0, 0, rf, ack);
    n_checks++;
    if (rf != 0) begin
      n_fail++;
      $display("FAIL after_abort_miss: got refill way %0d expected 0", rf);
    end
  endtask

  task automatic test_back_to_back();
    int rf, ack;
    do_reset();
    txn(1'b0, 2, 4'b0000, 0, 100, 1'b0, 0, rf, ack);
    txn(1'b0, 2, 4'b0001, 0, 100, 1'b1, 0, rf, ack);
    txn(1'b0, 2, 4'b0001, 0, 100, 1'b1, 0, rf, ack);
    txn(1'b1, 2, 4'b0001, 0, 100, 1'b1, 0, rf, ack);
    txn(1'b0, 2, 4'b0000, 0, 100, 1'b0, 0, rf, ack);
    check_ages_model(2);
  endtask

  task automatic test_random();
    int rf, ack;
    do_reset();
    for (int i = 0; i < 250; i++) begin
      txn(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), WAYS'($urandom),
          int'($urandom_range(0, 2)), int'($urandom_range(40, 100)),
          (i != 249) && ($urandom_range(0, 3) == 0), 0, rf, ack);
    end
    for (int s = 0; s < 4; s++) check_ages_model(s);
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    int rf, ack;
    do_reset();
    txn(1'b0, 0, 4'b0000, 0, 100, 1'b0, 0, rf, ack);
    txn(1'b0, 0, 4'b0000, 0, 100, 1'b0, 0, rf, ack);
    for (int i = 0; i < 3; i++) txn(1'b0, 0, 4'b0001, 0, 100, 1'b0, 0, rf, ack);
    n_checks++;
    if (stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
      n_fail++;
      $display("FAIL stats_count: got hits=%0d misses=%0d expected 3 and 2", stat_hits, stat_misses);
    end
    do_reset();
    #1;
    n_checks++;
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got hits=%0d misses=%0d expected 0 and 0", stat_hits, stat_misses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_refill_and_hit();
    test_lru_victims();
    test_write();
    test_reset_abort();
    test_back_to_back();
    test_random();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
